// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 (x^7+x^3+1) serial checker with flywheel,
// saturating error/bit counters and windowed loss-of-lock detection.
module prbs7_checker #(
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
    localparam logic [BW-1:0] WIN_V  = BW'(WIN);
    localparam logic [EW-1:0] LOSS_V = EW'(LOSS_THR);

    logic [0:0]    state;
    logic [6:0]    hist;
    logic [2:0]    fill;
    logic [MW-1:0] match;
    logic [BW-1:0] win_bits, wb_nx;
    logic [EW-1:0] win_errs, we_nx;
    logic          expected, miss;

    always_comb begin
        expected = hist[6] ^ hist[2];
        miss     = bit_in ^ expected;
        wb_nx    = win_bits + BW'(1);
        we_nx    = win_errs + EW'(miss);
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            err       <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err <= en && state == LOCKED && miss;
            if (en && state == SEARCH) begin
                hist <= {hist[5:0], bit_in};
                // an all-zero history is never a valid PRBS window, so it cannot build match
                if (fill != 3'd7) fill <= fill + 3'd1;
                else if (!miss && hist != '0) begin
                    match <= match + MW'(1);
                    if (match + MW'(1) == LOCK_V) begin
                        state    <= LOCKED;
                        win_bits <= '0;
                        win_errs <= '0;
                    end
                end else match <= '0;
            end
            if (en && state == LOCKED) begin
                hist     <= {hist[5:0], expected};
                win_bits <= (wb_nx == WIN_V) ? '0 : wb_nx;
                win_errs <= (wb_nx == WIN_V) ? '0 : we_nx;
                if (we_nx >= LOSS_V) begin
                    state <= SEARCH;
                    fill  <= '0;
                    match <= '0;
                    hist  <= '0;
                end
            end
            if (clr_cnt) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (en && state == LOCKED) begin
                if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
                if (miss && err_count != '1) err_count <= err_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: randomized scoreboard bench for prbs7_checker (16-bit and 4-bit counter builds).
module tb_prbs7_checker;
    logic        clk = 0, rst = 1, en = 0, bit_in = 0, clr_cnt = 0;
    logic        locked, err, locked4, err4;
    logic [15:0] err_count, bit_count;
    logic [3:0]  err_count4, bit_count4;
    logic        en_s;
    logic [43:0] sb[$];
    int          checks = 0, errors = 0;
    int          lock_at;

    bit          gh[$];
    logic [6:0]  gseed;

    bit          m_locked, m_err;
    bit          mh[$];
    int          m_match, m_wb, m_we, m_ec, m_bc, m_ec4, m_bc4;

    prbs7_checker dut (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count)
    );
    prbs7_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked4), .err(err4), .err_count(err_count4), .bit_count(bit_count4)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Stream source: first 7 bits are the seed, then b[n] = b[n-7] ^ b[n-3]
    function automatic bit gen_next();
        bit b;
        b = (gh.size() < 7) ? gseed[gh.size()] : (gh[0] ^ gh[4]);
        gh.push_back(b);
        if (gh.size() > 7) void'(gh.pop_front());
        return b;
    endfunction

    function automatic int sat(int v, int max);
        return (v < max) ? v + 1 : v;
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_err = 0; mh.delete();
        m_match = 0; m_wb = 0; m_we = 0; m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
    endfunction

    // Reference: a queue of the last 7 history bits (oldest first); prediction is oldest ^ 3rd-newest
    function automatic logic [43:0] model(bit b, bit c);
        bit p, any;
        p = (mh.size() == 7) ? (mh[0] ^ mh[4]) : 1'b0;
        m_err = 0;
        if (!m_locked) begin
            any = 0;
            foreach (mh[i]) any |= mh[i];
            if (mh.size() == 7) begin
                if (b == p && any) begin
                    m_match++;
                    if (m_match == 16) begin m_locked = 1; m_wb = 0; m_we = 0; end
                end else m_match = 0;
            end
            mh.push_back(b);
            if (mh.size() > 7) void'(mh.pop_front());
        end else begin
            mh.push_back(p);
            void'(mh.pop_front());
            m_bc = sat(m_bc, 65535); m_bc4 = sat(m_bc4, 15);
            if (b != p) begin
                m_err = 1; m_we++;
                m_ec = sat(m_ec, 65535); m_ec4 = sat(m_ec4, 15);
            end
            m_wb++;
            if (m_we >= 8) begin m_locked = 0; mh.delete(); m_match = 0; end
            if (m_wb == 64) begin m_wb = 0; m_we = 0; end
        end
        if (c) begin m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0; end
        return {m_locked, m_err, 16'(m_ec), 16'(m_bc), m_locked, m_err, 4'(m_ec4), 4'(m_bc4)};
    endfunction

    always @(posedge clk or posedge rst) en_s <= rst ? 1'b0 : en;

    always @(negedge clk) begin
        if (en_s) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: got output with no expected entry");
            end else
                chk("scoreboard", {locked, err, err_count, bit_count, locked4, err4, err_count4, bit_count4},
                    sb.pop_front());
        end else if (!rst) chk("idle_err", {err, err4}, 0);
    end

    task automatic drive(input bit e, input bit b, input bit c);
        en = e; bit_in = b; clr_cnt = c;
        if (e) sb.push_back(model(b, c));
        @(posedge clk); #1;
    endtask

    task automatic good(input int n);
        repeat (n) drive(1, gen_next(), 0);
    endtask

    task automatic bad();
        drive(1, !gen_next(), 0);
    endtask

    task automatic align();
        while (m_wb != 0) good(1);
    endtask

    task automatic do_reset(input string name);
        en = 0;
        @(negedge clk); #1;
        rst = 1;
        #1;
        chk(name, {locked, err, err_count, bit_count, locked4, err4, err_count4, bit_count4}, 0);
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_state", {locked, err, err_count, bit_count, locked4, err4, err_count4, bit_count4}, 0);
        @(posedge clk); #1;
        rst = 0;

        gseed = 7'h01; gh.delete();
        good(22);
        chk("acq_before_23", locked, 0);
        good(1);
        chk("acq_at_23", locked, 1);
        good(977);
        chk("clean_err_count", err_count, 0);
        chk("clean_bit_count", bit_count, 977);

        bad();
        chk("single_err", err, 1);
        chk("single_count", err_count, 1);
        chk("single_locked", locked, 1);
        good(1);
        chk("flywheel_err", err, 0);
        chk("flywheel_locked", locked, 1);

        align();
        drive(1, gen_next(), 1);
        chk("clr_count", err_count, 0);
        for (int i = 0; i < 7; i++) begin bad(); good(1); end
        chk("burst7_locked", locked, 1);
        bad();
        chk("burst_loss", locked, 0);
        chk("burst_err", err, 1);
        chk("burst_count", err_count, 8);
        good(22);
        chk("relock_before_23", locked, 0);
        good(1);
        chk("relock_at_23", locked, 1);

        align();
        good(60);
        repeat (4) bad();
        repeat (3) begin good($urandom_range(0, 10)); bad(); end
        chk("split7_locked", locked, 1);
        chk("split7_count", err_count, 15);

        align();
        repeat (6) begin good(5); bad(); end
        chk("sat4_hold", err_count4, 15);
        chk("sat16_count", err_count, 21);
        drive(1, !gen_next(), 1);
        chk("clr_err_pulse", err, 1);
        chk("clr_coincident", err_count, 0);
        chk("clr_coincident4", err_count4, 0);

        do_reset("async_reset");
        repeat (500) drive(1, 0, 0);
        chk("stuck0_locked", locked, 0);
        repeat (500) drive(1, 1, 0);
        chk("stuck1_locked", locked, 0);

        do_reset("async_reset2");
        gseed = 7'h01; gh.delete();
        lock_at = 0;
        for (int i = 1; i <= 1000; i++) begin
            repeat ($urandom_range(0, 3)) drive(0, 1'($urandom_range(0, 1)), 0);
            drive(1, gen_next(), 0);
            if (lock_at == 0 && locked) lock_at = i;
        end
        chk("gap_lock_at", lock_at, 23);
        chk("gap_err_count", err_count, 0);
        chk("gap_bit_count", bit_count, 977);

        do_reset("async_reset3");
        gseed = 7'($urandom_range(1, 127)); gh.delete();
        good(22);
        chk("rseed_before_23", locked, 0);
        good(1);
        chk("rseed_at_23", locked, 1);
        good(200);
        chk("rseed_err_count", err_count, 0);

        en = 0;
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
